mult_leak_monitor: RTL and testbench
====================================

MULT_LEAK_MONITOR -- requirements
Module: mult_leak_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width per lane (>=2).
REQ-002 SHALL have parameter LANES, default 2, number of multiplier lanes in lockstep (>=2).
REQ-003 SHALL have parameter CNT_W, default 8, width of skew counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  launch all lanes; honoured only in IDLE.
REQ-007 SHALL have port early_exit  input  1  mode select, sampled with start: 0 = constant-time, 1 = data-dependent.
REQ-008 SHALL have port multiplier  input  LANES*WIDTH  per-lane multipliers, lane i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port multiplicand  input  LANES*WIDTH  per-lane multiplicands, same packing.
REQ-010 SHALL have port product  output  LANES*2*WIDTH  per-lane unsigned products, lane i at [i*2*WIDTH +: 2*WIDTH].
REQ-011 SHALL have port lane_done  output  LANES  per-lane completion, held until next accepted start.
REQ-012 SHALL have port busy  output  1  high in RUN and DONE.
REQ-013 SHALL have port product_valid  output  1  one-cycle pulse when all lanes complete.
REQ-014 SHALL have port leak  output  1  sticky: lanes completed in different cycles.
REQ-015 SHALL have port leak_done  output  1  high from first lane completion until next accepted start.
REQ-016 SHALL have port skew  output  CNT_W  cycles between first and last lane completion.

Function
REQ-017 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when all lane_done bits set; DONE -> IDLE after exactly one cycle.
REQ-018 SHALL, on start in IDLE at edge T, latch operands and mode, clear accumulators, lane_done, leak, leak_done and skew.
REQ-019 SHALL perform one unsigned shift-add iteration per lane per RUN cycle: if current LSB of shifted multiplier is 1, add multiplicand shifted by iteration index into 2*WIDTH accumulator; no overflow is possible.
REQ-020 SHALL set lane_done[i] at edge T+L_i: L_i = WIDTH in constant-time mode; L_i = max(1, index of highest set multiplier bit + 1) in early-exit mode (multiplier 0 gives L_i = 1).
REQ-021 SHALL stop iterating a done lane; its product output holds the final value from edge T+L_i.
REQ-022 SHALL pulse product_valid at edge T+max(L_i)+1 (DONE state), for one cycle.
REQ-023 SHALL set leak at the edge where at least one lane completes while another remains incomplete; leak holds until next accepted start.
REQ-024 SHALL increment skew each RUN cycle after first completion while any lane is incomplete, saturating at 2^CNT_W-1; final value = max(L_i)-min(L_i).
REQ-025 SHALL ignore start in RUN and DONE; operand/mode changes mid-run SHALL have no effect.
REQ-026 SHALL accept start asserted in the cycle after DONE (back-to-back runs).

Reset
REQ-027 SHALL on rst force IDLE and clear product, lane_done, busy, product_valid, leak, leak_done, skew to 0.
REQ-028 SHALL abort an in-progress run on rst with no product_valid pulse; rst SHALL dominate a simultaneous start.

Configuration
REQ-029 SHALL honour macro MULT_LEAK_SKEW_EN: defined -> skew counter per REQ-024; undefined -> counter not built, skew tied to 0, leak and all other behaviour unchanged.

Verification
REQ-030 SHALL cover: WIDTH=4, LANES=2, constant mode, lane0 1x3, lane1 8x3 -> both lane_done at T+4, product 3 and 24, product_valid at T+5, leak=0, skew=0.
REQ-031 SHALL cover: same operands, early_exit=1 -> lane0 done T+1, lane1 done T+4, leak=1 from T+1, leak_done=1 from T+1, skew=3, product_valid at T+5.
REQ-032 SHALL cover: early mode, multiplier 0 and 15 x 15 -> products 0 and 225, L=1 and 4, skew=3.
REQ-033 SHALL cover: rst asserted at T+2 of a run -> all outputs 0 next edge, no product_valid, fresh start then completes normally.
REQ-034 SHALL cover: start held high continuously -> runs back-to-back, each product_valid followed by new start accepted in IDLE, leak cleared at each new start.
REQ-035 SHALL cover: build without MULT_LEAK_SKEW_EN, scenario REQ-031 -> skew=0, leak=1.

Source files
------------

// File: rtl/mult_leak_monitor.sv
// Lockstep shift-add multipliers that flag data-dependent completion timing.
// Optional skew counter is built when MULT_LEAK_SKEW_EN is defined.
module mult_leak_monitor #(
    parameter int WIDTH = 4,
    parameter int LANES = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       early_exit,
    input  logic [LANES*WIDTH-1:0]     multiplier,
    input  logic [LANES*WIDTH-1:0]     multiplicand,
    output logic [LANES*2*WIDTH-1:0]   product,
    output logic [LANES-1:0]           lane_done,
    output logic                       busy,
    output logic                       product_valid,
    output logic                       leak,
    output logic                       leak_done,
    output logic [CNT_W-1:0]           skew
);

    localparam int K_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic                 mode;
    logic [K_W-1:0]       iter;
    logic [WIDTH-1:0]     mp  [LANES];
    logic [2*WIDTH-1:0]   mc  [LANES];
    logic [2*WIDTH-1:0]   acc [LANES];
    logic [LANES-1:0]     done_q;
    logic [LANES-1:0]     done_nx;
    logic [LANES-1:0]     fin;
    logic                 leak_q;
    logic                 accept;

    assign accept = (state == IDLE) && start;

    // A lane finishes on its last fixed iteration, or early once no set bits remain.
    always_comb begin
        fin     = '0;
        done_nx = done_q;
        for (int i = 0; i < LANES; i++) begin
            fin[i] = (iter == K_LAST) ||
                     (mode && (mp[i][WIDTH-1:1] == '0));
            done_nx[i] = done_q[i] | ((state == RUN) & fin[i]);
        end
    end

    // Next-state logic: DONE lasts exactly one cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (&done_q) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Operand latch, per-lane shift-add iterations, completion and leak tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode   <= 1'b0;
            iter   <= '0;
            done_q <= '0;
            leak_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                mp[i]  <= '0;
                mc[i]  <= '0;
                acc[i] <= '0;
            end
        end else if (accept) begin
            mode   <= early_exit;
            iter   <= '0;
            done_q <= '0;
            leak_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                mp[i]  <= multiplier[i*WIDTH +: WIDTH];
                mc[i]  <= {{WIDTH{1'b0}}, multiplicand[i*WIDTH +: WIDTH]};
                acc[i] <= '0;
            end
        end else if (state == RUN) begin
            iter   <= iter + 1'b1;
            done_q <= done_nx;
            if ((|(done_nx & ~done_q)) && !(&done_nx)) leak_q <= 1'b1;
            for (int i = 0; i < LANES; i++) begin
                if (!done_q[i]) begin
                    if (mp[i][0]) acc[i] <= acc[i] + mc[i];
                    mp[i] <= mp[i] >> 1;
                    mc[i] <= mc[i] << 1;
                end
            end
        end
    end

`ifdef MULT_LEAK_SKEW_EN
    logic [CNT_W-1:0] skew_q;

    // Count cycles spent with some but not all lanes finished.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            skew_q <= '0;
        end else if ((state == RUN) && (|done_q) && !(&done_q) &&
                     (skew_q != {CNT_W{1'b1}})) begin
            skew_q <= skew_q + 1'b1;
        end
    end

    assign skew = skew_q;
`else
    assign skew = '0;
`endif

    // Pack lane accumulators onto the product bus.
    always_comb begin
        product = '0;
        for (int i = 0; i < LANES; i++) begin
            product[i*2*WIDTH +: 2*WIDTH] = acc[i];
        end
    end

    assign lane_done     = done_q;
    assign busy          = (state != IDLE);
    assign product_valid = (state == DONE);
    assign leak          = leak_q;
    assign leak_done     = |done_q;

endmodule

// File: tb/tb_mult_leak_monitor.sv
// Scoreboard bench for mult_leak_monitor (WIDTH=4, LANES=2).
// Expected skew follows MULT_LEAK_SKEW_EN as defined for the build.
module tb_mult_leak_monitor;

    localparam int WIDTH = 4;
    localparam int LANES = 2;
    localparam int CNT_W = 8;
`ifdef MULT_LEAK_SKEW_EN
    localparam bit SKEW_ON = 1'b1;
`else
    localparam bit SKEW_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             early_exit;
    logic [7:0]       multiplier;
    logic [7:0]       multiplicand;
    logic [15:0]      product;
    logic [1:0]       lane_done;
    logic             busy;
    logic             product_valid;
    logic             leak;
    logic             leak_done;
    logic [CNT_W-1:0] skew;

    typedef struct {
        logic [7:0] p0;
        logic [7:0] p1;
        logic       lk;
        logic [7:0] sk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mult_leak_monitor #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .early_exit(early_exit),
        .multiplier(multiplier), .multiplicand(multiplicand),
        .product(product), .lane_done(lane_done), .busy(busy),
        .product_valid(product_valid), .leak(leak),
        .leak_done(leak_done), .skew(skew)
    );

    always #5 clk = ~clk;

    function automatic int exp_len(logic [3:0] m, bit early);
        if (!early) return WIDTH;
        for (int b = WIDTH - 1; b >= 0; b--) if (m[b]) return b + 1;
        return 1;
    endfunction

    // Pop and compare whenever the DUT announces a result.
    always @(negedge clk) begin
        exp_t e;
        if (product_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: product_valid=1 with no run pending");
            end else begin
                e = sb.pop_front();
                if (product !== {e.p1, e.p0}) begin
                    errors++;
                    $display("FAIL sb_product: got %h want %h", product, {e.p1, e.p0});
                end
                checks++;
                if (leak !== e.lk) begin
                    errors++;
                    $display("FAIL sb_leak: got %b want %b", leak, e.lk);
                end
                checks++;
                if (skew !== e.sk) begin
                    errors++;
                    $display("FAIL sb_skew: got %0d want %0d", skew, e.sk);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; early_exit = 1'b0;
        multiplier = 8'h00; multiplicand = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({product, lane_done, busy, product_valid, leak, leak_done, skew} !== '0) begin
            errors++;
            $display("FAIL reset_state: p=%h ld=%b b=%b pv=%b lk=%b lkd=%b sk=%0d",
                     product, lane_done, busy, product_valid, leak, leak_done, skew);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_case(logic [3:0] a0, logic [3:0] b0,
                            logic [3:0] a1, logic [3:0] b1, bit early);
        int l0, l1, mx, mn, esk;
        exp_t e;
        logic [1:0] ed;
        l0 = exp_len(a0, early);
        l1 = exp_len(a1, early);
        mx = (l0 > l1) ? l0 : l1;
        mn = (l0 < l1) ? l0 : l1;
        e.p0 = 8'(a0) * 8'(b0);
        e.p1 = 8'(a1) * 8'(b1);
        e.lk = (l0 != l1);
        e.sk = SKEW_ON ? 8'(mx - mn) : 8'd0;
        @(negedge clk);
        start = 1'b1; early_exit = early;
        multiplier = {a1, a0}; multiplicand = {b1, b0};
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; early_exit = ~early;
        multiplier = 8'($urandom); multiplicand = 8'($urandom);
        checks++;
        if (busy !== 1'b1 || lane_done !== 2'b00) begin
            errors++;
            $display("FAIL accept: busy=%b lane_done=%b want 1/00", busy, lane_done);
        end
        for (int n = 1; n <= mx + 2; n++) begin
            @(posedge clk);
            #1;
            ed = {1'(n >= l1), 1'(n >= l0)};
            esk = (SKEW_ON && n > mn) ? (((n < mx) ? n : mx) - mn) : 0;
            checks++;
            if (lane_done !== ed) begin
                errors++;
                $display("FAIL lane_done n=%0d: got %b want %b", n, lane_done, ed);
            end
            checks++;
            if (busy !== 1'(n <= mx + 1) || product_valid !== 1'(n == mx + 1)) begin
                errors++;
                $display("FAIL busy_valid n=%0d: got %b%b want %b%b", n,
                         busy, product_valid, 1'(n <= mx + 1), 1'(n == mx + 1));
            end
            checks++;
            if (leak !== 1'((l0 != l1) && n >= mn) || leak_done !== 1'(n >= mn)) begin
                errors++;
                $display("FAIL leak n=%0d: got %b/%b want %b/%b", n, leak, leak_done,
                         1'((l0 != l1) && n >= mn), 1'(n >= mn));
            end
            checks++;
            if (skew !== 8'(esk)) begin
                errors++;
                $display("FAIL skew n=%0d: got %0d want %0d", n, skew, esk);
            end
            if (n >= l0) begin
                checks++;
                if (product[7:0] !== e.p0) begin
                    errors++;
                    $display("FAIL lane0_hold n=%0d: got %0d want %0d", n, product[7:0], e.p0);
                end
            end
            if (n >= l1) begin
                checks++;
                if (product[15:8] !== e.p1) begin
                    errors++;
                    $display("FAIL lane1_hold n=%0d: got %0d want %0d", n, product[15:8], e.p1);
                end
            end
        end
    endtask

    task automatic test_abort();
        @(negedge clk);
        start = 1'b1; early_exit = 1'b1;
        multiplier = 8'h81; multiplicand = 8'h33;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({product, lane_done, busy, product_valid, leak, leak_done, skew} !== '0) begin
            errors++;
            $display("FAIL abort_clear: p=%h ld=%b b=%b pv=%b lk=%b lkd=%b sk=%0d",
                     product, lane_done, busy, product_valid, leak, leak_done, skew);
        end
        rst = 1'b0; start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b want 0", busy);
        end
        run_case(4'd1, 4'd3, 4'd8, 4'd3, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t ea, eb;
        bit seen;
        ea.p0 = 8'd3; ea.p1 = 8'd24; ea.lk = 1'b1;
        ea.sk = SKEW_ON ? 8'd3 : 8'd0;
        eb.p0 = 8'd10; eb.p1 = 8'd63; eb.lk = 1'b0; eb.sk = 8'd0;
        @(negedge clk);
        start = 1'b1; early_exit = 1'b1;
        multiplier = 8'h81; multiplicand = 8'h33;
        sb.push_back(ea);
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || leak !== 1'b1) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b leak=%b want 0/1", busy, leak);
        end
        early_exit = 1'b0;
        multiplier = 8'h75; multiplicand = 8'h92;
        sb.push_back(eb);
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || leak !== 1'b0 || lane_done !== 2'b00 || leak_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b leak=%b ld=%b lkd=%b want 1/0/00/0",
                     busy, leak, lane_done, leak_done);
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (product_valid === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL b2b_timeout: product_valid got 0 want 1 within 10 cycles");
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        logic [15:0] r;
        for (int k = 0; k < 6; k++) begin
            r = 16'($urandom);
            run_case(r[3:0], r[7:4], r[11:8], r[15:12], 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        run_case(4'd1, 4'd3, 4'd8, 4'd3, 1'b0);
        run_case(4'd1, 4'd3, 4'd8, 4'd3, 1'b1);
        run_case(4'd0, 4'd9, 4'd15, 4'd15, 1'b1);
        test_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d results pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
